// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator.
// Free-running horizontal/vertical counters produce pixel coordinates and a
// pixel request for an external pixel source. The source answers PIPE_LAT
// cycles later, so the blanking and sync flags travel through a matching
// delay line before the final output register drives the DAC pins.
//
// Handshake: pixel_req is a pure request strobe with no back-pressure. The
// source must present the colour for a requested coordinate exactly PIPE_LAT
// cycles later; data presented while the delayed active bit is low is dropped.
//
// PIPE_LAT is meant to stay within 0..7.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_req,
    output logic       line_start,
    output logic       frame_start,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    // Region boundaries, all expressed in counter units.
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Raster position.
    logic [9:0] r_h;
    logic [9:0] r_v;

    // Decoded position flags, valid in the same cycle as the counters.
    logic w_h_last;
    logic w_v_last;
    logic w_active;
    logic w_hsync_raw;
    logic w_vsync_raw;

    // Flags after the PIPE_LAT delay line, aligned with the returned colour.
    logic w_act_d;
    logic w_hs_d;
    logic w_vs_d;

    // Output register contents.
    logic [7:0] r_red;
    logic [7:0] r_grn;
    logic [7:0] r_blu;
    logic       r_blank_n;
    logic       r_hs_n;
    logic       r_vs_n;

    // Decode the current counter position into region flags.
    always_comb begin
        w_h_last    = (r_h == H_LAST);
        w_v_last    = (r_v == V_LAST);
        w_active    = (r_h < H_ACT_END) && (r_v < V_ACT_END);
        w_hsync_raw = (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
        w_vsync_raw = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);
    end

    // Horizontal counter wraps every line; vertical advances only on the last
    // pixel of a line, so the bottom-right pixel wraps both together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (w_h_last) begin
            r_h <= 10'd0;
            r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    // Delay line that holds the position flags while the source fetches the
    // colour. With zero latency the flags feed the output register directly.
    generate
        if (PIPE_LAT == 0) begin : g_no_dly
            assign w_act_d = w_active;
            assign w_hs_d  = w_hsync_raw;
            assign w_vs_d  = w_vsync_raw;
        end else begin : g_dly
            // Each stage is {active, hsync_raw, vsync_raw}.
            logic [2:0] r_dly [PIPE_LAT];

            // Shift the flags one stage per clock; reset empties the line so
            // no stale sync or active state survives into the new frame.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        r_dly[i] <= 3'b000;
                    end
                end else begin
                    r_dly[0] <= {w_active, w_hsync_raw, w_vsync_raw};
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign {w_act_d, w_hs_d, w_vs_d} = r_dly[PIPE_LAT-1];
        end
    endgenerate

    // Final output register: colour is gated by the delayed active bit so
    // nothing the source drives during blanking ever reaches the DAC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_red     <= 8'h00;
            r_grn     <= 8'h00;
            r_blu     <= 8'h00;
            r_blank_n <= 1'b0;
            r_hs_n    <= 1'b1;
            r_vs_n    <= 1'b1;
        end else begin
            r_red     <= w_act_d ? pix_r : 8'h00;
            r_grn     <= w_act_d ? pix_g : 8'h00;
            r_blu     <= w_act_d ? pix_b : 8'h00;
            r_blank_n <= w_act_d;
            r_hs_n    <= ~w_hs_d;
            r_vs_n    <= ~w_vs_d;
        end
    end

    // Coordinate and strobe outputs come straight from the counters; the
    // start pulses are masked by reset so none fire while it is held.
    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign pixel_req   = w_active;
    assign line_start  = (r_h == 10'd0) && !reset;
    assign frame_start = (r_h == 10'd0) && (r_v == 10'd0) && !reset;

    // DAC-side pins.
    assign VGA_R       = r_red;
    assign VGA_G       = r_grn;
    assign VGA_B       = r_blu;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_HS      = r_hs_n;
    assign VGA_VS      = r_vs_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = clk;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: four instances with different geometries and
// latencies share clock, reset and (except the default one) colour inputs.
// Expected outputs come from a cycle-count model: cycles since reset give the
// raster position by division/modulo, and each output is the region rule
// applied to the position PIPE_LAT+1 cycles earlier.
module tb_vga_timing_ctrl;

    localparam int NMAX = 20000;
    localparam int NI   = 4;

    typedef struct {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        int pl;
    } cfg_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] pix_r, pix_g, pix_b;     // shared source for instances 1..3
    logic [7:0] pd_r, pd_g, pd_b;        // coordinate-echo source for instance 0

    logic [9:0] o_x     [NI];
    logic [9:0] o_y     [NI];
    logic       o_req   [NI];
    logic       o_ls    [NI];
    logic       o_fs    [NI];
    logic       o_hs    [NI];
    logic       o_vs    [NI];
    logic [7:0] o_r     [NI];
    logic [7:0] o_g     [NI];
    logic [7:0] o_b     [NI];
    logic       o_blank [NI];
    logic       o_syncn [NI];
    logic       o_vclk  [NI];

    // Instance 0: full default timing, latency 1, fed by a coordinate echo.
    vga_timing_ctrl u_def (
        .clk(clk), .reset(reset), .pix_r(pd_r), .pix_g(pd_g), .pix_b(pd_b),
        .pixel_x(o_x[0]), .pixel_y(o_y[0]), .pixel_req(o_req[0]),
        .line_start(o_ls[0]), .frame_start(o_fs[0]),
        .VGA_HS(o_hs[0]), .VGA_VS(o_vs[0]),
        .VGA_R(o_r[0]), .VGA_G(o_g[0]), .VGA_B(o_b[0]),
        .VGA_BLANK_N(o_blank[0]), .VGA_SYNC_N(o_syncn[0]), .VGA_CLK(o_vclk[0])
    );

    // Instance 1: default line timing, short frame, latency 0.
    vga_timing_ctrl #(.V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .PIPE_LAT(0)) u_p0 (
        .clk(clk), .reset(reset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pixel_x(o_x[1]), .pixel_y(o_y[1]), .pixel_req(o_req[1]),
        .line_start(o_ls[1]), .frame_start(o_fs[1]),
        .VGA_HS(o_hs[1]), .VGA_VS(o_vs[1]),
        .VGA_R(o_r[1]), .VGA_G(o_g[1]), .VGA_B(o_b[1]),
        .VGA_BLANK_N(o_blank[1]), .VGA_SYNC_N(o_syncn[1]), .VGA_CLK(o_vclk[1])
    );

    // Instance 2: default line timing, short frame, latency 7.
    vga_timing_ctrl #(.V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .PIPE_LAT(7)) u_p7 (
        .clk(clk), .reset(reset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pixel_x(o_x[2]), .pixel_y(o_y[2]), .pixel_req(o_req[2]),
        .line_start(o_ls[2]), .frame_start(o_fs[2]),
        .VGA_HS(o_hs[2]), .VGA_VS(o_vs[2]),
        .VGA_R(o_r[2]), .VGA_G(o_g[2]), .VGA_B(o_b[2]),
        .VGA_BLANK_N(o_blank[2]), .VGA_SYNC_N(o_syncn[2]), .VGA_CLK(o_vclk[2])
    );

    // Instance 3: tiny raster so many full frames and wraps occur, latency 3.
    vga_timing_ctrl #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .PIPE_LAT(3)) u_sm (
        .clk(clk), .reset(reset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pixel_x(o_x[3]), .pixel_y(o_y[3]), .pixel_req(o_req[3]),
        .line_start(o_ls[3]), .frame_start(o_fs[3]),
        .VGA_HS(o_hs[3]), .VGA_VS(o_vs[3]),
        .VGA_R(o_r[3]), .VGA_G(o_g[3]), .VGA_B(o_b[3]),
        .VGA_BLANK_N(o_blank[3]), .VGA_SYNC_N(o_syncn[3]), .VGA_CLK(o_vclk[3])
    );

    // ---------------- scoreboard state ----------------
    cfg_t        cfg [NI];
    int          t_hist  [NMAX];   // cycles since last reset, after edge n
    bit          rst_hist[NMAX];   // reset value sampled at edge n
    logic [23:0] ps_hist [NMAX];   // shared colour sampled at edge n
    logic [23:0] pd_hist [NMAX];   // instance-0 colour sampled at edge n
    int          n;
    int          phase;
    int          cur_k;
    int          total;
    int          bad;

    int hs_low [NI];
    int vs_low [NI];
    int last_ls[NI];
    int last_fs[NI];
    bit prev_hs[NI];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cycle=%0d got=%0h exp=%0h", tag, cur_k, n, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int htot(input cfg_t c);
        return c.ha + c.hfp + c.hs + c.hbp;
    endfunction
    function automatic int vtot(input cfg_t c);
        return c.va + c.vfp + c.vs + c.vbp;
    endfunction
    function automatic int hof(input cfg_t c, input int t);
        return t % htot(c);
    endfunction
    function automatic int vof(input cfg_t c, input int t);
        return (t / htot(c)) % vtot(c);
    endfunction

    // Source for instance 0: answers one cycle late with {x, y, A5}.
    function automatic logic [23:0] defsrc(input int t);
        int h;
        int v;
        h = hof(cfg[0], t);
        v = vof(cfg[0], t);
        return {8'(h), 8'(v), 8'hA5};
    endfunction

    task automatic check_inst(input int k, input bit rst_cur);
        cfg_t        c;
        int          t, h, v, ts, hh, vv, ht, vt;
        bit          dflt, a;
        logic [23:0] px;
        logic [7:0]  er, eg, eb;
        bit          eblank, ehs, evs;
        c  = cfg[k];
        ht = htot(c);
        vt = vtot(c);
        t  = t_hist[n];
        h  = hof(c, t);
        v  = vof(c, t);
        cur_k = k;

        chk("x", 32'(o_x[k]), 32'(h));
        chk("y", 32'(o_y[k]), 32'(v));
        chk("req", 32'(o_req[k]), 32'((h < c.ha) && (v < c.va)));
        chk("line_start", 32'(o_ls[k]), 32'((h == 0) && !rst_cur));
        chk("frame_start", 32'(o_fs[k]), 32'((h == 0) && (v == 0) && !rst_cur));

        // Output registers reflect the raster PIPE_LAT+1 cycles back unless a
        // reset hit the delay line or the output register within that window.
        dflt = (n - c.pl < 0);
        for (int j = n - c.pl; j <= n; j++) begin
            if (j >= 0 && rst_hist[j]) dflt = 1'b1;
        end
        if (dflt) begin
            eblank = 1'b0; er = 8'h00; eg = 8'h00; eb = 8'h00; ehs = 1'b1; evs = 1'b1;
        end else begin
            ts = t_hist[n - 1 - c.pl];
            hh = hof(c, ts);
            vv = vof(c, ts);
            a  = (hh < c.ha) && (vv < c.va);
            px = (k == 0) ? pd_hist[n] : ps_hist[n];
            eblank = a;
            er  = a ? px[23:16] : 8'h00;
            eg  = a ? px[15:8]  : 8'h00;
            eb  = a ? px[7:0]   : 8'h00;
            ehs = !((hh >= c.ha + c.hfp) && (hh < c.ha + c.hfp + c.hs));
            evs = !((vv >= c.va + c.vfp) && (vv < c.va + c.vfp + c.vs));
        end
        chk("blank_n", 32'(o_blank[k]), 32'(eblank));
        chk("vga_r", 32'(o_r[k]), 32'(er));
        chk("vga_g", 32'(o_g[k]), 32'(eg));
        chk("vga_b", 32'(o_b[k]), 32'(eb));
        chk("vga_hs", 32'(o_hs[k]), 32'(ehs));
        chk("vga_vs", 32'(o_vs[k]), 32'(evs));
        chk("sync_n", 32'(o_syncn[k]), 32'd0);
        chk("vga_clk", 32'(o_vclk[k]), 32'(clk));

        // Observed-waveform measurements; any reset restarts them.
        if (rst_hist[n]) begin
            hs_low[k] = 0; vs_low[k] = 0; last_ls[k] = -1; last_fs[k] = -1;
        end
        if (!o_hs[k]) hs_low[k]++;
        else if (hs_low[k] > 0) begin
            chk("hs_low_len", 32'(hs_low[k]), 32'(c.hs));
            hs_low[k] = 0;
        end
        if (!o_vs[k]) vs_low[k]++;
        else if (vs_low[k] > 0) begin
            chk("vs_low_len", 32'(vs_low[k]), 32'(c.vs * ht));
            vs_low[k] = 0;
        end
        if (o_ls[k]) begin
            if (last_ls[k] >= 0) chk("line_period", 32'(n - last_ls[k]), 32'(ht));
            last_ls[k] = n;
        end
        if (o_fs[k]) begin
            if (last_fs[k] >= 0) chk("frame_period", 32'(n - last_fs[k]), 32'(ht * vt));
            last_fs[k] = n;
        end
        if (prev_hs[k] && !o_hs[k])
            chk("hs_fall_x", 32'(o_x[k]), 32'((c.ha + c.hfp + c.pl + 1) % ht));
        prev_hs[k] = o_hs[k];
    endtask

    // Named scenario points, expressed in cycles since the last reset.
    task automatic targeted(input bit rst_cur);
        int t, h, v;
        t = t_hist[n];
        cur_k = 0;
        if (phase == 1 && t == 0 && !rst_cur) begin
            chk("rel_frame_start", 32'(o_fs[0]), 32'd1);
            chk("rel_x", 32'(o_x[0]), 32'd0);
            chk("rel_y", 32'(o_y[0]), 32'd0);
            chk("rel_blank", 32'(o_blank[0]), 32'd0);
            chk("rel_hs", 32'(o_hs[0]), 32'd1);
            chk("rel_vs", 32'(o_vs[0]), 32'd1);
        end
        if (t == 2400) begin
            chk("v3_x", 32'(o_x[0]), 32'd0);
            chk("v3_y", 32'(o_y[0]), 32'd3);
        end
        if (t == 2401) chk("v3_pre_blank", 32'(o_blank[0]), 32'd0);
        if (t == 2402) begin
            chk("v3_blank", 32'(o_blank[0]), 32'd1);
            chk("v3_r", 32'(o_r[0]), 32'h00);
            chk("v3_g", 32'(o_g[0]), 32'h03);
            chk("v3_b", 32'(o_b[0]), 32'hA5);
        end
        if (phase == 1) begin
            cur_k = 1;
            h = hof(cfg[1], t);
            v = vof(cfg[1], t);
            if (h == 700) chk("ff_hblank_col", {8'h0, o_r[1], o_g[1], o_b[1]}, 32'h0);
            if (v >= cfg[1].va && h == 100)
                chk("ff_vblank_col", {8'h0, o_r[1], o_g[1], o_b[1]}, 32'h0);
        end
    endtask

    // ---------------- driver ----------------
    // Apply the inputs for the next edge, check the current state, then clock.
    task automatic step(input bit rst, input logic [23:0] psh);
        logic [23:0] pdv;
        pdv = (n >= 1) ? defsrc(t_hist[n-1]) : 24'h0;
        reset = rst;
        {pix_r, pix_g, pix_b} = psh;
        {pd_r, pd_g, pd_b}    = pdv;
        #1;
        if (n >= 0) begin
            for (int k = 0; k < NI; k++) check_inst(k, rst);
            targeted(rst);
        end
        @(posedge clk);
        n++;
        rst_hist[n] = rst;
        ps_hist[n]  = psh;
        pd_hist[n]  = pdv;
        t_hist[n]   = (rst || n == 0) ? 0 : t_hist[n-1] + 1;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
        cfg[1] = '{640, 16, 96, 48, 6, 1, 2, 3, 0};
        cfg[2] = '{640, 16, 96, 48, 6, 1, 2, 3, 7};
        cfg[3] = '{16, 4, 6, 6, 12, 2, 2, 4, 3};
        for (int k = 0; k < NI; k++) begin
            hs_low[k] = 0; vs_low[k] = 0; last_ls[k] = -1; last_fs[k] = -1; prev_hs[k] = 1'b1;
        end
        n = -1; phase = 0; total = 0; bad = 0; cur_k = 0;
        reset = 1'b1;
        {pix_r, pix_g, pix_b} = 24'h0;
        {pd_r, pd_g, pd_b}    = 24'h0;

        repeat (10) step(1'b1, 24'h0);

        // Clean run with a constant white source; ends at h=400, v=12 of u_def.
        phase = 1;
        repeat (10000) step(1'b0, 24'hFFFFFF);
        step(1'b1, 24'hFFFFFF);
        step(1'b0, 24'hFFFFFF);

        // Random colours with occasional single- and multi-cycle resets.
        phase = 2;
        repeat (8000) begin
            step($urandom_range(0, 399) == 0, 24'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch widths in pixels.
REQ-003 The module SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical active, front porch, sync and back porch widths in lines.
REQ-004 The module SHALL have parameter PIPE_LAT, default 1, range 0..7: cycles from pixel_x/pixel_y to valid pix_r/g/b from the downstream pixel source.
REQ-005 The module SHALL have one clock and a synchronous, active-high reset: clk and reset, as listed below.
REQ-006 clk  in  1  25 MHz pixel clock, sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 pix_r, pix_g, pix_b  in  8 each  pixel colour returned by the source PIPE_LAT cycles after the request.
REQ-009 pixel_x, pixel_y  out  10 each  current horizontal and vertical counter values.
REQ-010 pixel_req  out  1  high when the counters are inside the active area.
REQ-011 line_start  out  1  one-cycle pulse at h=0.
REQ-012 frame_start  out  1  one-cycle pulse at h=0, v=0.
REQ-013 VGA_HS, VGA_VS  out  1 each  active-low horizontal and vertical sync.
REQ-014 VGA_R, VGA_G, VGA_B  out  8 each  registered colour to the DAC.
REQ-015 VGA_BLANK_N  out  1  registered; low outside the active area.
REQ-016 VGA_SYNC_N  out  1  constant 0.
REQ-017 VGA_CLK  out  1  equal to clk.

Function
REQ-018 Horizontal counter h SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters, 800), then wrap to 0.
REQ-019 Vertical counter v SHALL increment only in a cycle where h = H_TOTAL-1, and SHALL count 0..V_TOTAL-1 (525), then wrap to 0 (an H_TOTAL-1, V_TOTAL-1 cycle wraps both counters).
REQ-020 Line order SHALL be: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, +H_SYNC) = [656,752), back porch; vertical order is the same, with sync lines [490,492).
REQ-021 pixel_x = h and pixel_y = v, combinationally from the registered counters.
REQ-022 pixel_req = (h < H_ACTIVE) && (v < V_ACTIVE).
REQ-023 line_start = (h == 0) && !reset; frame_start = (h == 0) && (v == 0) && !reset.
REQ-024 active, hsync_raw and vsync_raw SHALL pass through a delay line of PIPE_LAT stages, then one output register, so all VGA_* outputs lag the counters by PIPE_LAT+1 cycles.
REQ-025 At each output register update: VGA_R/G/B take pix_r/g/b if the delayed active bit is 1, else 8'h00; VGA_BLANK_N takes the delayed active bit.
REQ-026 VGA_HS/VGA_VS SHALL be 0 when the delayed hsync_raw/vsync_raw is 1, else 1.
REQ-027 When PIPE_LAT = 0, colour SHALL be sampled in the same cycle as the request, and outputs lag the counters by exactly 1 cycle.
REQ-028 Pixel data present on pix_r/g/b outside the delayed active window SHALL never reach VGA_R/G/B.

Reset
REQ-029 While reset is high at a clk edge: h = 0, v = 0, all delay-line stages cleared (active 0, sync inactive).
REQ-030 Also on reset: VGA_R/G/B = 0, VGA_BLANK_N = 0, VGA_HS = 1, VGA_VS = 1.
REQ-031 Reset asserted mid-frame SHALL take effect at the next edge, with no partial line completed.
REQ-032 In the first cycle after reset is released, h = 0, v = 0 and frame_start = 1.

Verification
REQ-033 Reset, then run 420000 cycles -> frame_start period 420000 and line_start period 800; VGA_HS low exactly 96 cycles per line; VGA_VS low exactly 1600 cycles per frame.
REQ-034 PIPE_LAT=1; source returns {pixel_x[7:0], pixel_y[7:0], 8'hA5} one cycle late -> at the cycle where VGA_BLANK_N first rises in line v=3, VGA_R=0, VGA_G=3, VGA_B=A5, exactly 2 cycles after pixel_x=0.
REQ-035 Drive pix_r/g/b = FF constantly -> VGA_R/G/B = 0 whenever VGA_BLANK_N = 0, e.g. at h=700 and in lines v=480..524.
REQ-036 Assert reset at h=400, v=200 for 1 cycle -> next cycle h=0, v=0, VGA_BLANK_N=0, VGA_HS=VGA_VS=1, and frame_start=1 one cycle after release.
REQ-037 Wrap check h=799, v=524 -> next cycle h=0, v=0; h=799, v=100 -> next cycle h=0, v=101.
REQ-038 PIPE_LAT=0 and PIPE_LAT=7 -> the falling edge of VGA_HS lags h=656 by exactly 1 and 8 cycles respectively.
